// File: rtl/stairwell_pkg.sv
// Shared types and helpers for the stairwell light controller.
// The state encoding, press counter width and press-source picker live here.
package stairwell_pkg;

    typedef enum logic [1:0] {
        OFF        = 2'd0,
        ON         = 2'd1,
        FORCED_ON  = 2'd2,
        FORCED_OFF = 2'd3
    } state_t;

    localparam int PRESS_CNT_W = 8;

    // Lowest set bit index; simultaneous rises credit the lowest-numbered button.
    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Per-bit rising-edge detector on already-synchronous button levels.
// Reset loads the current levels so a button held through reset is not seen as a press.
module rise_detect #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_rise
);

    logic [W-1:0] r_d_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_d_q <= i_d;
        end else begin
            r_d_q <= i_d;
        end
    end

    assign o_rise = i_d & ~r_d_q;

endmodule

// File: rtl/stairwell_light_ctrl.sv
// Timed shared stairwell light: any button rise starts/restarts an ON_TIME on-period,
// with a warning window at the end and maintenance force_on/force_off overrides.
module stairwell_light_ctrl
    import stairwell_pkg::*;
#(
    parameter int N_BTN     = 4,
    parameter int ON_TIME   = 20,
    parameter int WARN_TIME = 3,
    localparam int RW = $clog2(ON_TIME),
    localparam int SW = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
    input  logic                   clock_1Hz,
    input  logic                   reset,
    input  logic [N_BTN-1:0]       btn,
    input  logic                   force_on,
    input  logic                   force_off,
    output logic                   light,
    output logic                   warn,
    output logic [RW-1:0]          remaining,
    output logic [SW-1:0]          last_src,
    output logic [PRESS_CNT_W-1:0] press_count
);

    localparam logic [RW-1:0]          RELOAD  = RW'(ON_TIME - 1);
    localparam logic [RW-1:0]          WARN_V  = RW'(WARN_TIME);
    localparam logic [RW-1:0]          REM_ONE = RW'(1);
    localparam logic [PRESS_CNT_W-1:0] CNT_ONE = PRESS_CNT_W'(1);

    state_t                 r_state;
    logic [RW-1:0]          r_remaining;
    logic [SW-1:0]          r_last_src;
    logic [PRESS_CNT_W-1:0] r_press_count;

    state_t                 w_state_nxt;
    logic [RW-1:0]          w_rem_nxt;
    logic [SW-1:0]          w_last_nxt;
    logic [PRESS_CNT_W-1:0] w_cnt_nxt;
    logic                   w_accept;
    logic [N_BTN-1:0]       w_rise;

    rise_detect #(
        .W(N_BTN)
    ) u_rise_detect (
        .clk    (clock_1Hz),
        .rst    (reset),
        .i_d    (btn),
        .o_rise (w_rise)
    );

    always_ff @(posedge clock_1Hz) begin
        if (reset) begin
            r_state       <= OFF;
            r_remaining   <= '0;
            r_last_src    <= '0;
            r_press_count <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_remaining   <= w_rem_nxt;
            r_last_src    <= w_last_nxt;
            r_press_count <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_remaining;
        w_accept    = 1'b0;
        if (force_off) begin
            w_state_nxt = FORCED_OFF;
            w_rem_nxt   = '0;
        end else begin
            case (r_state)
                FORCED_OFF: begin
                    w_state_nxt = OFF;
                    w_rem_nxt   = '0;
                end
                FORCED_ON: begin
                    // Releasing force_on hands over to a full timed period.
                    w_state_nxt = force_on ? FORCED_ON : ON;
                    w_rem_nxt   = RELOAD;
                end
                default: begin
                    if (force_on) begin
                        w_state_nxt = FORCED_ON;
                        w_rem_nxt   = RELOAD;
                    end else if (|w_rise) begin
                        w_accept    = 1'b1;
                        w_state_nxt = ON;
                        w_rem_nxt   = RELOAD;
                    end else if (r_state == ON && r_remaining != '0) begin
                        w_rem_nxt   = r_remaining - REM_ONE;
                    end else begin
                        w_state_nxt = OFF;
                        w_rem_nxt   = '0;
                    end
                end
            endcase
        end
    end

    always_comb begin
        w_last_nxt = r_last_src;
        w_cnt_nxt  = r_press_count;
        if (w_accept) begin
            w_last_nxt = SW'(lowest_set(16'(w_rise)));
            if (r_press_count != '1) w_cnt_nxt = r_press_count + CNT_ONE;
        end
    end

    assign light       = (r_state == ON) || (r_state == FORCED_ON);
    assign warn        = (r_state == ON) && (r_remaining < WARN_V);
    assign remaining   = r_remaining;
    assign last_src    = r_last_src;
    assign press_count = r_press_count;

endmodule

// File: tb/tb_stairwell_light_ctrl.sv
// Bench for stairwell_light_ctrl: directed scenarios plus randomized traffic
// checked against a countdown-of-lit-cycles reference model.
module tb_stairwell_light_ctrl;

    localparam int N      = 4;
    localparam int ON_T   = 20;
    localparam int WARN_T = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn;
    logic       force_on;
    logic       force_off;
    logic       light;
    logic       warn;
    logic [4:0] remaining;
    logic [1:0] last_src;
    logic [7:0] press_count;
    logic [16:0] obs;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: m_left = lit timed cycles still to show (0 = dark).
    int         m_left;
    bit         m_fo;
    bit         m_fn;
    logic [3:0] m_prev;
    int         m_last;
    int         m_cnt;

    always #5 clk = ~clk;

    stairwell_light_ctrl #(
        .N_BTN     (N),
        .ON_TIME   (ON_T),
        .WARN_TIME (WARN_T)
    ) dut (
        .clock_1Hz   (clk),
        .reset       (reset),
        .btn         (btn),
        .force_on    (force_on),
        .force_off   (force_off),
        .light       (light),
        .warn        (warn),
        .remaining   (remaining),
        .last_src    (last_src),
        .press_count (press_count)
    );

    assign obs = {light, warn, remaining, last_src, press_count};

    function automatic logic [16:0] exp_vec();
        logic       l;
        logic       w;
        logic [4:0] r;
        l = m_fn || (m_left > 0);
        w = !m_fn && (m_left > 0) && (m_left <= WARN_T);
        r = m_fn ? 5'(ON_T - 1) : ((m_left > 0) ? 5'(m_left - 1) : 5'd0);
        return {l, w, r, 2'(m_last), 8'(m_cnt)};
    endfunction

    // Drive one cycle of inputs, advance model at the edge, settle 1 time unit.
    task automatic tick(input logic [3:0] b, input logic fo, input logic fn, input logic rs);
        logic [3:0] rise;
        btn = b; force_off = fo; force_on = fn; reset = rs;
        @(posedge clk);
        rise   = b & ~m_prev;
        m_prev = b;
        if (rs) begin
            m_fo = 0; m_fn = 0; m_left = 0; m_last = 0; m_cnt = 0;
        end else if (fo) begin
            m_fo = 1; m_fn = 0; m_left = 0;
        end else if (m_fo) begin
            m_fo = 0;
        end else if (fn) begin
            m_fn = 1; m_left = 0;
        end else if (m_fn) begin
            m_fn = 0; m_left = ON_T;
        end else if (rise != 0) begin
            m_left = ON_T;
            if (m_cnt < 255) m_cnt++;
            for (int i = N - 1; i >= 0; i--) if (rise[i]) m_last = i;
        end else if (m_left > 0) begin
            m_left--;
        end
        #1;
    endtask

    task automatic do_reset(input logic [3:0] b);
        tick(b, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        do_reset(4'b0000);
        n_checks++;
        if (obs !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_values: got %h want %h", obs, 17'd0);
        end
    endtask

    task automatic test_single_press();
        logic [4:0] er;
        do_reset(4'b0000);
        tick(4'b0000, 0, 0, 0);
        tick(4'b0100, 0, 0, 0);
        n_checks++;
        if (last_src !== 2'd2 || press_count !== 8'd1) begin
            n_fail++;
            $display("FAIL single_src_cnt: got src=%0d cnt=%0d want src=2 cnt=1", last_src, press_count);
        end
        for (int i = 1; i <= 25; i++) begin
            er = (i <= ON_T) ? 5'(ON_T - i) : 5'd0;
            n_checks++;
            if (light !== (i <= ON_T) || warn !== (i >= 18 && i <= 20) || remaining !== er) begin
                n_fail++;
                $display("FAIL single_timing cyc%0d: got l=%b w=%b r=%0d want l=%b w=%b r=%0d",
                         i, light, warn, remaining, (i <= ON_T), (i >= 18 && i <= 20), er);
            end
            tick(4'b0000, 0, 0, 0);
        end
    endtask

    task automatic test_retrigger();
        do_reset(4'b0000);
        tick(4'b0001, 0, 0, 0);
        for (int t = 1; t <= 34; t++) begin
            tick((t == 10) ? 4'b1000 : 4'b0000, 0, 0, 0);
            n_checks++;
            if (light !== (t + 1 <= 30) || warn !== (t + 1 >= 28 && t + 1 <= 30)) begin
                n_fail++;
                $display("FAIL retrigger cyc%0d: got l=%b w=%b want l=%b w=%b",
                         t + 1, light, warn, (t + 1 <= 30), (t + 1 >= 28 && t + 1 <= 30));
            end
        end
        n_checks++;
        if (last_src !== 2'd3 || press_count !== 8'd2) begin
            n_fail++;
            $display("FAIL retrigger_stats: got src=%0d cnt=%0d want src=3 cnt=2", last_src, press_count);
        end
    endtask

    task automatic test_back_to_back();
        do_reset(4'b0000);
        tick(4'b1010, 0, 0, 0);
        n_checks++;
        if (press_count !== 8'd1 || last_src !== 2'd1) begin
            n_fail++;
            $display("FAIL simultaneous: got src=%0d cnt=%0d want src=1 cnt=1", last_src, press_count);
        end
        for (int i = 0; i < 19; i++) tick(4'b0000, 0, 0, 0);
        n_checks++;
        if (remaining !== 5'd0 || light !== 1'b1) begin
            n_fail++;
            $display("FAIL at_zero_setup: got l=%b r=%0d want l=1 r=0", light, remaining);
        end
        tick(4'b0001, 0, 0, 0);
        n_checks++;
        if (light !== 1'b1 || remaining !== 5'(ON_T - 1) || press_count !== 8'd2 || last_src !== 2'd0) begin
            n_fail++;
            $display("FAIL press_at_zero: got l=%b r=%0d cnt=%0d src=%0d want l=1 r=19 cnt=2 src=0",
                     light, remaining, press_count, last_src);
        end
        n_checks++;
        if (obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL press_at_zero_model: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_force_on();
        int lit;
        do_reset(4'b0000);
        tick(4'b0001, 0, 0, 0);
        for (int i = 0; i < 17; i++) tick(4'b0000, 0, 0, 0);
        n_checks++;
        if (warn !== 1'b1) begin
            n_fail++;
            $display("FAIL force_on_setup: got w=%b want w=1", warn);
        end
        for (int i = 0; i < 5; i++) begin
            tick((i == 1) ? 4'b0010 : 4'b0000, 0, 1, 0);
            n_checks++;
            if (light !== 1'b1 || warn !== 1'b0 || remaining !== 5'(ON_T - 1) || press_count !== 8'd1) begin
                n_fail++;
                $display("FAIL force_on_hold cyc%0d: got l=%b w=%b r=%0d cnt=%0d want l=1 w=0 r=19 cnt=1",
                         i, light, warn, remaining, press_count);
            end
        end
        lit = 0;
        for (int i = 0; i < 25; i++) begin
            tick(4'b0000, 0, 0, 0);
            if (light) lit++;
        end
        n_checks++;
        if (lit != ON_T) begin
            n_fail++;
            $display("FAIL force_on_release: got lit=%0d want lit=%0d", lit, ON_T);
        end
    endtask

    task automatic test_force_off();
        logic [7:0] saved;
        do_reset(4'b0000);
        tick(4'b0001, 0, 0, 0);
        for (int i = 0; i < 5; i++) tick(4'b0000, 0, 0, 0);
        saved = press_count;
        for (int i = 0; i < 4; i++) begin
            tick((i == 1) ? 4'b0001 : 4'b0000, 1, 0, 0);
            n_checks++;
            if (light !== 1'b0 || remaining !== 5'd0 || warn !== 1'b0 || press_count !== saved) begin
                n_fail++;
                $display("FAIL force_off_hold cyc%0d: got l=%b r=%0d cnt=%0d want l=0 r=0 cnt=%0d",
                         i, light, remaining, press_count, saved);
            end
        end
        for (int i = 0; i < 10; i++) begin
            tick(4'b0000, 0, 0, 0);
            n_checks++;
            if (light !== 1'b0) begin
                n_fail++;
                $display("FAIL force_off_release cyc%0d: got l=%b want l=0", i, light);
            end
        end
        tick(4'b0010, 0, 0, 0);
        n_checks++;
        if (light !== 1'b1 || press_count !== saved + 8'd1) begin
            n_fail++;
            $display("FAIL force_off_repress: got l=%b cnt=%0d want l=1 cnt=%0d", light, press_count, saved + 8'd1);
        end
    endtask

    task automatic test_hold_through_reset();
        do_reset(4'b0100);
        do_reset(4'b0100);
        for (int i = 0; i < 5; i++) begin
            tick(4'b0100, 0, 0, 0);
            n_checks++;
            if (light !== 1'b0 || press_count !== 8'd0) begin
                n_fail++;
                $display("FAIL held_btn cyc%0d: got l=%b cnt=%0d want l=0 cnt=0", i, light, press_count);
            end
        end
        tick(4'b0000, 0, 0, 0);
        tick(4'b0100, 0, 0, 0);
        n_checks++;
        if (light !== 1'b1 || press_count !== 8'd1 || last_src !== 2'd2) begin
            n_fail++;
            $display("FAIL held_btn_repress: got l=%b cnt=%0d src=%0d want l=1 cnt=1 src=2",
                     light, press_count, last_src);
        end
        for (int i = 0; i < 4; i++) tick(4'b0000, 0, 0, 0);
        tick(4'b0000, 0, 1, 1);
        n_checks++;
        if (obs !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_in_on: got %h want %h", obs, 17'd0);
        end
    endtask

    task automatic test_saturation();
        do_reset(4'b0000);
        for (int i = 0; i < 260; i++) begin
            tick(4'b0001, 0, 0, 0);
            tick(4'b0000, 0, 0, 0);
        end
        n_checks++;
        if (press_count !== 8'd255) begin
            n_fail++;
            $display("FAIL saturation: got cnt=%0d want cnt=255", press_count);
        end
    endtask

    task automatic test_random();
        logic [3:0] b;
        logic       fo;
        logic       fn;
        logic       rs;
        logic [16:0] e;
        b = 4'b0000;
        do_reset(b);
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) b[$urandom_range(0, 3)] = ~b[$urandom_range(0, 3)];
            if ($urandom_range(0, 40) == 0) b = 4'($urandom_range(0, 15));
            fo = ($urandom_range(0, 39) == 0);
            fn = ($urandom_range(0, 29) == 0);
            rs = ($urandom_range(0, 299) == 0);
            tick(b, fo, fn, rs);
            e = exp_vec();
            n_checks++;
            if (light !== e[16] || warn !== e[15]) begin
                n_fail++;
                $display("FAIL rand_light_warn cyc%0d: got l=%b w=%b want l=%b w=%b", i, light, warn, e[16], e[15]);
            end
            n_checks++;
            if (remaining !== e[14:10]) begin
                n_fail++;
                $display("FAIL rand_remaining cyc%0d: got %0d want %0d", i, remaining, e[14:10]);
            end
            n_checks++;
            if (last_src !== e[9:8] || press_count !== e[7:0]) begin
                n_fail++;
                $display("FAIL rand_stats cyc%0d: got src=%0d cnt=%0d want src=%0d cnt=%0d",
                         i, last_src, press_count, e[9:8], e[7:0]);
            end
        end
    endtask

    initial begin
        btn = '0; force_on = 0; force_off = 0; reset = 1;
        m_left = 0; m_fo = 0; m_fn = 0; m_prev = '0; m_last = 0; m_cnt = 0;
        test_reset();
        test_single_press();
        test_retrigger();
        test_back_to_back();
        test_force_on();
        test_force_off();
        test_hold_through_reset();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stairwell_light_ctrl.md
Name: stairwell_light_ctrl

Overview:
- Sequences one shared timed light relay between N_BTN wall buttons, e.g. the push buttons on each floor of a stairwell.
- Any button's rising edge starts or restarts an ON_TIME-cycle on-period.
- A warning flag marks the last WARN_TIME cycles of the on-period.
- Maintenance force_on/force_off inputs override the buttons.
- Sits between the debounced button inputs and the lamp relay driver, clocked from the 1 Hz system tick.

Parameters:
- N_BTN, 4, number of button requesters (1..16).
- ON_TIME, 20, on-period length in cycles after the last accepted press (≥2).
- WARN_TIME, 3, length of the warning window at the end of the on-period (1..ON_TIME-1).

Ports:
- clock_1Hz  input  1  system tick clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- btn  input  N_BTN  button levels, already debounced and synchronous.
- force_on  input  1  maintenance: hold light on.
- force_off  input  1  maintenance: hold light off, ignore buttons.
- light  output  1  relay drive.
- warn  output  1  high during the last WARN_TIME cycles of a timed on-period.
- remaining  output  $clog2(ON_TIME)  cycles left in the on-period minus one; 0 when not timing.
- last_src  output  $clog2(N_BTN) (min 1)  index of the button that made the most recent accepted press.
- press_count  output  8  saturating count of accepted presses.

Behaviour:
- Clock and reset:
  - One clock, clock_1Hz; reset is synchronous and active-high.
  - Reset gives state=OFF, light=0, warn=0, remaining=0, last_src=0, press_count=0, and edge-detector history = current btn.
  - A button held through reset therefore does not trigger on exit.
- States: OFF, ON, FORCED_ON, FORCED_OFF. All outputs are registered or decoded from registers only; there is no combinational path from inputs.
- Edge detection: rise[i] = btn[i] & ~btn_q[i]. btn_q updates every cycle in every state, including FORCED_OFF.
- Accepted press: any rise bit in OFF or ON with force_off=0 and force_on=0.
  - The lowest-index rising button wins and is written to last_src.
  - press_count increments by 1, saturating at 255.
- Timing, edge sampled at cycle k:
  - light=1 from k+1, and remaining=ON_TIME-1 at k+1.
  - remaining decrements by 1 each cycle.
  - In ON with remaining==0 and no accepted press, the next state is OFF.
  - Result: light is high exactly ON_TIME cycles after the last accepted press, and $fell(light) implies $past(rise, ON_TIME+1).
- Retrigger: an accepted press while in ON reloads remaining to ON_TIME-1, including when remaining==0 (no off gap).
- Simultaneous rises on several buttons count as one press.
- warn = (state==ON) && (remaining < WARN_TIME). It is never high in OFF or in forced states.
- Priority, evaluated per cycle: force_off > force_on > button presses.
- FORCED_OFF:
  - Entered from any state when force_off=1; light=0 next cycle, remaining=0.
  - Rises are ignored and not counted.
  - On release, go to OFF.
- FORCED_ON:
  - Entered from OFF or ON when force_on=1 and force_off=0; light=1, warn=0.
  - remaining holds ON_TIME-1, and rises are not counted.
  - On release, go to ON with remaining=ON_TIME-1, giving a full on-period afterwards.
- Reset mid-operation: the next cycle shows reset values regardless of state or force inputs.

Decomposition:
- Package stairwell_pkg holds:
  - typedef enum logic [1:0] state_t {OFF, ON, FORCED_ON, FORCED_OFF};
  - the PRESS_CNT_W=8 constant;
  - a function returning the lowest set bit index for last_src.
- Sub-module rise_detect, parameterised by width:
  - registered btn_q, with the synchronous reset loading the current input;
  - outputs the rise vector.
- The controller FSM, counter and statistics live in stairwell_light_ctrl.

Test Plan (N_BTN=4, ON_TIME=20, WARN_TIME=3):
- Reset with btn=0, then a one-cycle pulse on btn[2] → light=1 the next cycle for exactly 20 cycles; warn=1 on cycles 18–20 only; last_src=2; press_count=1; remaining counts 19→0.
- Pulse btn[0] at cycle 0, then btn[3] at cycle 10 → light stays high continuously until cycle 30 (20 cycles after the second press); warn only on cycles 28–30; last_src=3; press_count=2.
- btn[1] and btn[3] rise in the same cycle → press_count+=1 and last_src=1. Pressing at the remaining==0 cycle → no low cycle on light.
- force_on for 5 cycles during the warn window → warn=0 and light=1 throughout; after release, light stays on for 20 more cycles.
- force_off asserted mid on-period, with btn[0] pulsed during it → light=0 the next cycle; press_count unchanged; light stays 0 after release until a new rise.
- btn[2] held high across reset deassertion → no press accepted; light=0 and press_count=0 until btn[2] falls and rises again. A reset pulse in ON → light=0 and all counters 0 on the next cycle.
